fwvexrisc_wb_sram_target: RTL
=============================

FWVEXRISC_WB_SRAM_TARGET -- requirements
Module: fwvexrisc_wb_sram_target

Interface
REQ-001 Parameter ADDR_BITS, default 10, SHALL give the SRAM word-address width (2^ADDR_BITS 32-bit words; 4 KB at default).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, SHALL give the byte base of the decoded window; it SHALL be aligned to the window size.
REQ-003 clock  in  1  single clock for all state, rising edge.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 t_adr  in  32  Wishbone byte address.
REQ-006 t_dat_w  in  32  Wishbone write data.
REQ-007 t_dat_r  out  32  Wishbone read data.
REQ-008 t_cyc, t_stb, t_we  in  1 each  Wishbone cycle, strobe, write-enable.
REQ-009 t_sel  in  4  Wishbone byte-lane select.
REQ-010 t_ack, t_err  out  1 each  Wishbone normal and error termination.
REQ-011 sram_csb, sram_web  out  1 each  SRAM chip-select and write-enable, both active-low.
REQ-012 sram_addr  out  ADDR_BITS  SRAM word address, t_adr[ADDR_BITS+1:2].
REQ-013 sram_wmask  out  4  byte write mask, equal to t_sel.
REQ-014 sram_din  out  32  write data, equal to t_dat_w; sram_dout  in  32  read data, valid 1 cycle after the read access.

Function
REQ-015 The FSM SHALL have the states IDLE, RD_WAIT, ACK and ERR.
REQ-016 A request SHALL exist when the FSM is in IDLE with t_cyc and t_stb both high.
REQ-017 A request is in-range if t_adr[31:ADDR_BITS+2] equals BASE_ADDR[31:ADDR_BITS+2].
REQ-018 On an in-range request in IDLE, sram_csb SHALL go low combinationally in that cycle, and sram_web SHALL equal ~t_we.
REQ-019 sram_csb SHALL be high in every other state and cycle; the block SHALL never issue more than one SRAM access per beat.
REQ-020 In-range write: IDLE->ACK; t_ack high for exactly 1 cycle, the cycle after the request.
REQ-021 In-range read: IDLE->ACK, or IDLE->RD_WAIT->ACK per REQ-033; t_dat_r valid whenever t_ack is high.
REQ-022 Reads SHALL ignore t_sel and return the full word; a t_sel of 4'b0000 on a read is legal.
REQ-023 A write with t_sel of 4'b0000 SHALL still access the SRAM with an all-zero mask and SHALL be acked.
REQ-024 Out-of-range request: no SRAM access; IDLE->ERR; t_err high 1 cycle after the request; t_ack stays low.
REQ-025 ACK and ERR SHALL always return to IDLE, so a new request is sampled no earlier than the cycle after termination.
REQ-026 Bursts are handled as consecutive single beats: the initiator may hold t_cyc/t_stb and advance t_adr by 4 after each ack, giving one beat per 2 cycles (3 with REQ-033).
REQ-027 If t_cyc falls while in RD_WAIT, ACK or ERR, the FSM SHALL go to IDLE and suppress t_ack/t_err. A write already issued to the SRAM stands.
REQ-028 t_ack and t_err SHALL never both be high, and SHALL never be high in IDLE.
REQ-029 t_dat_r SHALL be 0 when t_ack is low.

Reset
REQ-030 While reset_n is low: FSM=IDLE, t_ack=0, t_err=0, t_dat_r=0, sram_csb=1, sram_web=1, and any read-data register=0.
REQ-031 Reset asserted mid-beat SHALL abort the beat with no termination; the first request after release SHALL be sampled on the first rising edge with reset_n high.

Configuration
REQ-032 Macro FWVEXRISC_WB_SRAM_RDREG_EN SHALL select registered read data.
REQ-033 Defined: reads pass IDLE->RD_WAIT->ACK; sram_dout is captured in a 32-bit register during RD_WAIT; t_ack comes 2 cycles after the request. Write latency is unchanged.
REQ-034 Undefined: RD_WAIT is unreachable; t_dat_r = sram_dout combinationally during ACK; read t_ack comes 1 cycle after the request.

Structure
REQ-035 Shared package fwvexrisc_wb_pkg SHALL hold the state encoding (IDLE=2'b00, RD_WAIT=2'b01, ACK=2'b10, ERR=2'b11) and the word-offset constant 2.
REQ-036 The verification environment SHALL provide behavioral sub-module fwvexrisc_sram_1rw (1-cycle read latency, byte mask) as the SRAM model; the RTL SHALL NOT instantiate it.

Verification
REQ-037 Write 0xDEADBEEF to 0x10, sel 4'b1111, then read 0x10 -> single t_ack per beat; read returns 0xDEADBEEF; read ack at +1 cycle (+2 with RDREG_EN).
REQ-038 Write 0x000000AA to 0x10, sel 4'b0001, over 0x11223344, then read -> 0x112233AA; read with sel 4'b0000 -> same full word.
REQ-039 Read 0x0000_1000 with ADDR_BITS=10, BASE_ADDR=0 -> t_err 1 cycle after request; t_ack low; sram_csb stays high.
REQ-040 8-beat read burst from 0x20 with t_stb held and t_adr +4 after each ack -> 8 acks, data equals words 8..15, one beat per 2 cycles (3 with RDREG_EN).
REQ-041 Drop t_cyc in the ACK cycle of a read -> no t_ack; next request served normally.
REQ-042 Assert reset_n low in RD_WAIT (RDREG_EN) -> all outputs at reset values immediately; the next read after release returns correct data.

Source files
------------

// File: rtl/fwvexrisc_wb_pkg.sv
// rtl/fwvexrisc_wb_pkg.sv - shared state encoding and address constants for the Wishbone SRAM target
package fwvexrisc_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RD_WAIT = 2'b01,
        ST_ACK     = 2'b10,
        ST_ERR     = 2'b11
    } state_t;

    // Byte address to word address shift for 32-bit words
    localparam int WORD_OFFSET = 2;

endpackage

// File: rtl/fwvexrisc_sram_1rw.sv
// rtl/fwvexrisc_sram_1rw.sv - behavioral single-port SRAM, 1-cycle read latency, byte write mask
module fwvexrisc_sram_1rw #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clock,
    input  logic                 csb,
    input  logic                 web,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [3:0]           wmask,
    input  logic [31:0]          din,
    output logic [31:0]          dout
);

    logic [31:0] r_mem [0:(1<<ADDR_BITS)-1];
    logic [31:0] r_dout;

    assign dout = r_dout;

    // One access per selected cycle: masked byte write, or full-word read registered for next cycle
    always_ff @(posedge clock) begin
        if (!csb) begin
            if (!web) begin
                if (wmask[0]) r_mem[addr][7:0]   <= din[7:0];
                if (wmask[1]) r_mem[addr][15:8]  <= din[15:8];
                if (wmask[2]) r_mem[addr][23:16] <= din[23:16];
                if (wmask[3]) r_mem[addr][31:24] <= din[31:24];
            end else begin
                r_dout <= r_mem[addr];
            end
        end
    end

endmodule

// File: rtl/fwvexrisc_wb_sram_target.sv
// rtl/fwvexrisc_wb_sram_target.sv - Wishbone single-beat target for a 1RW SRAM; FWVEXRISC_WB_SRAM_RDREG_EN registers read data
module fwvexrisc_wb_sram_target
    import fwvexrisc_wb_pkg::*;
#(
    parameter int          ADDR_BITS = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [31:0]          t_adr,
    input  logic [31:0]          t_dat_w,
    output logic [31:0]          t_dat_r,
    input  logic                 t_cyc,
    input  logic                 t_stb,
    input  logic                 t_we,
    input  logic [3:0]           t_sel,
    output logic                 t_ack,
    output logic                 t_err,
    output logic                 sram_csb,
    output logic                 sram_web,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic [3:0]           sram_wmask,
    output logic [31:0]          sram_din,
    input  logic [31:0]          sram_dout
);

    localparam int HI_LSB = ADDR_BITS + WORD_OFFSET;

    state_t r_state;
    state_t w_next;
    logic   w_req;
    logic   w_in_range;
    logic   w_access;
    logic   w_unused_adr_lsbs;

    // A request is only recognised in IDLE; reset_n gating keeps the SRAM deselected during reset
    assign w_req      = (r_state == ST_IDLE) && t_cyc && t_stb && reset_n;
    assign w_in_range = (t_adr[31:HI_LSB] == BASE_ADDR[31:HI_LSB]);
    assign w_access   = w_req && w_in_range;

    assign sram_csb   = ~w_access;
    assign sram_web   = w_access ? ~t_we : 1'b1;
    assign sram_addr  = t_adr[HI_LSB-1:WORD_OFFSET];
    assign sram_wmask = t_sel;
    assign sram_din   = t_dat_w;

    assign w_unused_adr_lsbs = &{1'b0, t_adr[WORD_OFFSET-1:0]};

    // Termination is withdrawn combinationally if the initiator drops the cycle
    assign t_ack = (r_state == ST_ACK) && t_cyc;
    assign t_err = (r_state == ST_ERR) && t_cyc;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: every beat terminates and returns to IDLE before the next one is sampled
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (!w_in_range) begin
                        w_next = ST_ERR;
                    end else if (t_we) begin
                        w_next = ST_ACK;
                    end else begin
`ifdef FWVEXRISC_WB_SRAM_RDREG_EN
                        w_next = ST_RD_WAIT;
`else
                        w_next = ST_ACK;
`endif
                    end
                end
            end
            ST_RD_WAIT: w_next = t_cyc ? ST_ACK : ST_IDLE;
            ST_ACK:     w_next = ST_IDLE;
            ST_ERR:     w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

`ifdef FWVEXRISC_WB_SRAM_RDREG_EN
    logic [31:0] r_rdata;

    // Capture SRAM output in the wait cycle so the bus sees a flop, not the macro output
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= 32'h0;
        end else if (r_state == ST_RD_WAIT) begin
            r_rdata <= sram_dout;
        end
    end

    assign t_dat_r = t_ack ? r_rdata : 32'h0;
`else
    assign t_dat_r = t_ack ? sram_dout : 32'h0;
`endif

endmodule
